// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared types and constants for the LED pattern sequencer
package led_seq_pkg;

    localparam int STEP_W = 8;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_CHASE = 2'd2,
        MODE_COUNT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - wrapping 0..DIV-1 counter that flags the last count as a tick
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clear in the same cycle restarts the period, so it suppresses the tick.
    assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - command-driven LED pattern scheduler; optional LED_SEQ_PWM_EN adds brightness PWM
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [STEP_W-1:0]   cmd_steps,
    output logic [NUM_LEDS-1:0] led,
    output logic                busy,
    output logic                done
`ifdef LED_SEQ_PWM_EN
    ,
    input  logic [7:0]          brightness
`endif
);

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    logic [STEP_W-1:0]     steps_q, steps_d;
    logic [STEP_W-1:0]     step_cnt_q, step_cnt_d;
    logic [NUM_LEDS-1:0]   pattern_q, pattern_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  accept;
    logic                  tick;

    function automatic logic [NUM_LEDS-1:0] next_pattern(mode_e m, logic [NUM_LEDS-1:0] p);
        case (m)
            MODE_BLINK: return ~p;
            MODE_CHASE: return {p[NUM_LEDS-2:0], p[NUM_LEDS-1]};
            MODE_COUNT: return p + 1'b1;
            default:    return '0;
        endcase
    endfunction

    function automatic logic [NUM_LEDS-1:0] init_pattern(mode_e m);
        case (m)
            MODE_BLINK: return '1;
            MODE_CHASE: return NUM_LEDS'(1);
            default:    return '0;
        endcase
    endfunction

    // Only an infinite run may be preempted; a finite run must finish first.
    assign cmd_ready = (state_q == ST_IDLE) || ((state_q == ST_RUN) && (steps_q == '0));
    assign accept    = cmd_valid && cmd_ready;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state_q == ST_RUN),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        steps_d    = steps_q;
        step_cnt_d = step_cnt_q;
        pattern_d  = pattern_q;

        case (state_q)
            ST_IDLE: ;
            ST_RUN: begin
                if (tick) begin
                    pattern_d = next_pattern(mode_q, pattern_q);
                    if (steps_q != '0) begin
                        step_cnt_d = step_cnt_q + 1'b1;
                        if (step_cnt_d == steps_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            mode_d     = mode_e'(cmd_mode);
            steps_d    = cmd_steps;
            step_cnt_d = '0;
            pattern_d  = init_pattern(mode_e'(cmd_mode));
            state_d    = ST_RUN;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_OFF;
            steps_q    <= '0;
            step_cnt_q <= '0;
            pattern_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            steps_q    <= steps_d;
            step_cnt_q <= step_cnt_d;
            pattern_q  <= pattern_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

`ifdef LED_SEQ_PWM_EN
    logic [7:0]          pwm_q, pwm_d;
    logic [7:0]          bright_q, bright_d;
    logic [NUM_LEDS-1:0] led_q, led_d;

    // The gate is computed from next-state values so led stays a plain register.
    always_comb begin
        pwm_d    = pwm_q + 8'd1;
        bright_d = accept ? brightness : bright_q;
        led_d    = (pwm_d < bright_d) ? pattern_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q    <= '0;
            bright_q <= '0;
            led_q    <= '0;
        end else begin
            pwm_q    <= pwm_d;
            bright_q <= bright_d;
            led_q    <= led_d;
        end
    end

    assign led = led_q;
`else
    assign led = pattern_q;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - randomized and directed bench for led_sequencer against a closed-form pattern model
module tb_led_sequencer;

    localparam int NL  = 4;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_mode = 2'd0;
    logic [7:0]    cmd_steps = 8'd0;
    logic          cmd_ready;
    logic [NL-1:0] led;
    logic          busy;
    logic          done;
`ifdef LED_SEQ_PWM_EN
    logic [7:0]    brightness = 8'd255;
`endif

    int passed = 0;
    int total = 0;
    int edges = 0;
    int bright_lat = 255;
    int last_m = 0;
    int last_s = 0;

    always #5 clk = ~clk;

    led_sequencer #(
        .NUM_LEDS (NL),
        .TICK_DIV (DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_steps  (cmd_steps),
        .led        (led),
        .busy       (busy),
        .done       (done)
`ifdef LED_SEQ_PWM_EN
        ,
        .brightness (brightness)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic check(string tag, int obs, int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Pattern after n steps, straight from the mode definitions.
    function automatic logic [NL-1:0] pat(int m, int n);
        case (m)
            1:       return (n % 2 == 0) ? {NL{1'b1}} : {NL{1'b0}};
            2:       return NL'(1) << (n % NL);
            3:       return NL'(n % (1 << NL));
            default: return '0;
        endcase
    endfunction

    function automatic int shown(int m, int n);
`ifdef LED_SEQ_PWM_EN
        if ((edges % 256) >= bright_lat) return 0;
`endif
        return int'(pat(m, n));
    endfunction

    task automatic run_cmd(int m, int s, int inf_cycles, bit hold_next, int nm, int ns, bit expect_now);
        int waits = 0;
        int last;
        cmd_mode  = 2'(m);
        cmd_steps = 8'(s);
        cmd_valid = 1'b1;
        while (!cmd_ready && waits < 200) begin
            tick();
            waits++;
        end
        check("accept_ready", int'(cmd_ready), 1);
        if (expect_now) check("held_accept_latency", waits, 0);
`ifdef LED_SEQ_PWM_EN
        bright_lat = int'(brightness);
`endif
        tick();
        cmd_valid = 1'b0;
        last_m = m;
        last_s = s;
        last = (s == 0) ? inf_cycles - 1 : s * DIV + 1;
        for (int t = 0; t <= last; t++) begin
            int n = t / DIV;
            if (s != 0 && n > s) n = s;
            check("led", int'(led), shown(m, n));
            check("busy", int'(busy), (s == 0 || t <= s * DIV) ? 1 : 0);
            check("done", int'(done), (s != 0 && t == s * DIV) ? 1 : 0);
            check("cmd_ready", int'(cmd_ready), (s == 0 || t > s * DIV) ? 1 : 0);
            if (hold_next && t == 2) begin
                cmd_valid = 1'b1;
                cmd_mode  = 2'(nm);
                cmd_steps = 8'(ns);
            end
            if (t != last) tick();
        end
    endtask

    task automatic idle_gap(int g);
        for (int i = 0; i < g; i++) begin
            tick();
            check("idle_led_hold", int'(led), shown(last_m, last_s));
            check("idle_busy", int'(busy), 0);
            check("idle_ready", int'(cmd_ready), 1);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_led"}, int'(led), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_ready"}, int'(cmd_ready), 1);
    endtask

    initial begin
        repeat (3) tick();
        check_reset_outputs("reset");
        #3 rst_n = 1'b1;
        edges = 0;
        tick();
        check_reset_outputs("post_reset");

        run_cmd(2, 5, 0, 1'b0, 0, 0, 1'b0);
        idle_gap(2);
        run_cmd(3, 17, 0, 1'b1, 2, 2, 1'b0);
        run_cmd(2, 2, 0, 1'b0, 0, 0, 1'b1);
        run_cmd(0, 3, 0, 1'b0, 0, 0, 1'b0);

        run_cmd(1, 0, 14, 1'b0, 0, 0, 1'b0);
        run_cmd(2, 0, 9, 1'b0, 0, 0, 1'b0);
        run_cmd(3, 3, 0, 1'b0, 0, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int m = int'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                run_cmd(m, 0, int'($urandom_range(1, 13)), 1'b0, 0, 0, 1'b0);
                m = int'($urandom_range(0, 3));
            end
            run_cmd(m, int'($urandom_range(1, 9)), 0, 1'b0, 0, 0, 1'b0);
            idle_gap(int'($urandom_range(0, 5)));
        end

        run_cmd(2, 0, 6, 1'b0, 0, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        tick();
        check_reset_outputs("held_reset");
        #3 rst_n = 1'b1;
        edges = 0;
        tick();
        check_reset_outputs("after_async_reset");

`ifdef LED_SEQ_PWM_EN
        brightness = 8'd64;
        run_cmd(2, 0, 256, 1'b0, 0, 0, 1'b0);
        brightness = 8'd0;
        run_cmd(1, 0, 64, 1'b0, 0, 0, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
